// File: rtl/zxuno_port_responder.sv
// ZX-Uno style register-port responder: an address port selects one of
// eight 8-bit registers, a data port writes (and optionally reads) it.
//
// Parameters:
//   ADDR_PORT   16-bit IO address of the register-select port
//   DATA_PORT   16-bit IO address of the register-data port
//   WAIT_CYCLES wait clocks inserted on each data-port access (0..15)
//
// Ports:
//   clk      system clock, CPU bus synchronous to it
//   rst      synchronous active-high reset
//   a        CPU address bus
//   din      CPU write data
//   iorq_n   CPU IORQ
//   m1_n     CPU M1 (low with IORQ = interrupt acknowledge, ignored)
//   rd_n     CPU RD
//   wr_n     CPU WR
//   dout     read data to CPU (8'hFF when not driving)
//   oe       high while dout is to be driven onto the bus
//   wait_n   CPU WAIT, low only while stretching a data-port access
//   reg_sel  current register address latch
//   reg_wr   one-clock pulse on each committed register write
//   regs     register file, reg n at bits [8n+7:8n]
//
// Build option:
//   RESPONDER_READBACK_EN  defined -> registers are readable;
//                          undefined -> write-only, oe=0, dout=8'hFF.

module zxuno_port_responder #(
  parameter logic [15:0] ADDR_PORT   = 16'hFC3B,
  parameter logic [15:0] DATA_PORT   = 16'hFD3B,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic [7:0]  dout,
  output logic        oe,
  output logic        wait_n,
  output logic [7:0]  reg_sel,
  output logic        reg_wr,
  output logic [63:0] regs
);

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;

  logic hit_addr;
  logic hit_data;
  logic hit;
  logic io_acc;
  logic wr_acc;
  logic commit;
  logic sel_ok;

  assign hit_addr = (a == ADDR_PORT);
  assign hit_data = (a == DATA_PORT);
  assign hit      = hit_addr | hit_data;

  // Interrupt acknowledge (M1 low with IORQ) is never an IO access.
  assign io_acc = !iorq_n && m1_n && (!rd_n || !wr_n);

  // A write wins over a simultaneous read.
  assign wr_acc = io_acc && !wr_n;

  assign sel_ok = (reg_sel < 8'd8);

  // Commit happens on the edge that enters ACT, using that edge's bus.
  assign commit = (state_nx == ACT) && (state != ACT) && wr_acc;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (io_acc && hit) begin
          if (hit_data && (WC != 4'd0)) begin
            state_nx = WAIT;
          end else begin
            state_nx = ACT;
          end
        end
      end
      WAIT: begin
        if (iorq_n) begin
          state_nx = IDLE;
        end else if (cnt <= 4'd1) begin
          state_nx = ACT;
        end
      end
      ACT: begin
        if (iorq_n) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
`ifdef RESPONDER_READBACK_EN
  // Remembers which port the current access decoded to, so a read
  // keeps returning the same source for the whole ACT phase.
  logic acc_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      reg_sel <= 8'd0;
      regs    <= 64'd0;
      reg_wr  <= 1'b0;
`ifdef RESPONDER_READBACK_EN
      acc_data <= 1'b0;
`endif
    end else begin
      reg_wr <= 1'b0;

      if (state == IDLE && state_nx == WAIT) begin
        cnt <= WC;
      end else if (state == WAIT && state_nx == WAIT) begin
        cnt <= cnt - 4'd1;
      end else begin
        cnt <= 4'd0;
      end

`ifdef RESPONDER_READBACK_EN
      if (state == IDLE && state_nx != IDLE) begin
        acc_data <= hit_data;
      end
`endif

      if (commit && hit_addr) begin
        reg_sel <= din;
      end

      if (commit && hit_data && sel_ok) begin
        regs[{reg_sel[2:0], 3'b000} +: 8] <= din;
        reg_wr <= 1'b1;
      end
    end
  end

  // ---------------- outputs ----------------
`ifdef RESPONDER_READBACK_EN
  logic [7:0] rd_data;

  always_comb begin
    rd_data = reg_sel;
    if (acc_data) begin
      if (sel_ok) begin
        rd_data = regs[{reg_sel[2:0], 3'b000} +: 8];
      end else begin
        rd_data = 8'hFF;
      end
    end
  end
`endif

  always_comb begin
    wait_n = 1'b1;
    oe     = 1'b0;
    dout   = 8'hFF;
    if (state == WAIT) begin
      wait_n = 1'b0;
    end
`ifdef RESPONDER_READBACK_EN
    if (state == ACT && !rd_n && wr_n) begin
      oe   = 1'b1;
      dout = rd_data;
    end
`endif
  end

endmodule

// File: tb/tb_zxuno_port_responder.sv
// Self-checking bench for zxuno_port_responder with a transaction-level
// reference model of the register file and bus timing.

module tb_zxuno_port_responder;

  localparam logic [15:0] ADDR_PORT = 16'hFC3B;
  localparam logic [15:0] DATA_PORT = 16'hFD3B;
  localparam int          WCYC      = 2;
  localparam int          HOLD      = 6;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic        iorq_n;
  logic        m1_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  dout;
  logic        oe;
  logic        wait_n;
  logic [7:0]  reg_sel;
  logic        reg_wr;
  logic [63:0] regs;

  int checks;
  int failures;

  logic [7:0] m_regs [8];
  logic [7:0] m_sel;

  zxuno_port_responder #(
    .ADDR_PORT  (ADDR_PORT),
    .DATA_PORT  (DATA_PORT),
    .WAIT_CYCLES(WCYC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .din    (din),
    .iorq_n (iorq_n),
    .m1_n   (m1_n),
    .rd_n   (rd_n),
    .wr_n   (wr_n),
    .dout   (dout),
    .oe     (oe),
    .wait_n (wait_n),
    .reg_sel(reg_sel),
    .reg_wr (reg_wr),
    .regs   (regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef RESPONDER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_pack();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_sel = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] addr);
    if (addr == ADDR_PORT) return m_sel;
    if (m_sel < 8) return m_regs[m_sel[2:0]];
    return 8'hFF;
  endfunction

  // Effect of one completed bus cycle on architectural state.
  task automatic model_write(input logic [15:0] addr, input logic [7:0] d);
    if (addr == ADDR_PORT) m_sel = d;
    else if (addr == DATA_PORT && m_sel < 8) m_regs[m_sel[2:0]] = d;
  endtask

  // ---------------- bus driver ----------------
  task automatic bus_idle();
    a      = 16'h0000;
    din    = 8'h00;
    iorq_n = 1'b1;
    m1_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
  endtask

  // Holds one IO cycle for HOLD clocks, then releases; returns what was
  // seen on wait_n, reg_wr, oe and dout over the cycle plus one idle clk.
  task automatic bus_cycle(
    input  logic [15:0] addr,
    input  logic [7:0]  d,
    input  bit          do_rd,
    input  bit          do_wr,
    output int          n_wait,
    output int          n_wr,
    output int          n_oe,
    output logic [7:0]  rd_val,
    output bit          dout_bad
  );
    n_wait = 0; n_wr = 0; n_oe = 0;
    rd_val = 8'hXX; dout_bad = 1'b0;
    @(negedge clk);
    a = addr; din = d; m1_n = 1'b1;
    iorq_n = 1'b0; rd_n = !do_rd; wr_n = !do_wr;
    for (int i = 0; i <= HOLD; i++) begin
      if (i == HOLD) begin
        @(negedge clk);
        bus_idle();
      end
      @(posedge clk);
      #1;
      if (wait_n === 1'b0) n_wait++;
      if (reg_wr === 1'b1) n_wr++;
      if (oe === 1'b1) begin
        n_oe++;
        rd_val = dout;
      end else if (dout !== 8'hFF) begin
        dout_bad = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({wait_n, oe, reg_wr} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl: wait_n/oe/reg_wr=%b expected 100",
               {wait_n, oe, reg_wr});
    end
    checks++;
    if (dout !== 8'hFF || reg_sel !== 8'h00 || regs !== 64'd0) begin
      failures++;
      $display("FAIL reset_data: dout=%h sel=%h regs=%h expected FF/00/0",
               dout, reg_sel, regs);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int nw, nr, no;
    logic [7:0] rv;
    bit bad;
    bus_cycle(ADDR_PORT, 8'h05, 0, 1, nw, nr, no, rv, bad);
    model_write(ADDR_PORT, 8'h05);
    checks++;
    if (reg_sel !== 8'h05 || nw != 0 || nr != 0) begin
      failures++;
      $display("FAIL basic_sel: sel=%h wait=%0d wr=%0d expected 05/0/0",
               reg_sel, nw, nr);
    end
    bus_cycle(DATA_PORT, 8'hA5, 0, 1, nw, nr, no, rv, bad);
    model_write(DATA_PORT, 8'hA5);
    checks++;
    if (nw != WCYC) begin
      failures++;
      $display("FAIL basic_wait: wait clocks=%0d expected %0d", nw, WCYC);
    end
    checks++;
    if (nr != 1) begin
      failures++;
      $display("FAIL basic_regwr: pulses=%0d expected 1", nr);
    end
    checks++;
    if (regs[47:40] !== 8'hA5 || regs !== model_pack()) begin
      failures++;
      $display("FAIL basic_regs: regs=%h expected %h", regs, model_pack());
    end
  endtask

  task automatic test_readback();
    int nw, nr, no;
    logic [7:0] rv;
    bit bad;
    bus_cycle(DATA_PORT, 8'h00, 1, 0, nw, nr, no, rv, bad);
    checks++;
    if (no != (RB ? HOLD - WCYC : 0) || nw != WCYC || bad) begin
      failures++;
      $display("FAIL rb_data_oe: oe=%0d wait=%0d bad=%0d expected %0d/%0d/0",
               no, nw, bad, RB ? HOLD - WCYC : 0, WCYC);
    end
    checks++;
    if (RB && rv !== model_read(DATA_PORT)) begin
      failures++;
      $display("FAIL rb_data_val: dout=%h expected %h",
               rv, model_read(DATA_PORT));
    end
    bus_cycle(ADDR_PORT, 8'h00, 1, 0, nw, nr, no, rv, bad);
    checks++;
    if (no != (RB ? HOLD : 0) || nw != 0 || bad) begin
      failures++;
      $display("FAIL rb_addr_oe: oe=%0d wait=%0d bad=%0d expected %0d/0/0",
               no, nw, bad, RB ? HOLD : 0);
    end
    checks++;
    if (RB && rv !== 8'h05) begin
      failures++;
      $display("FAIL rb_addr_val: dout=%h expected 05", rv);
    end
  endtask

  task automatic test_out_of_range();
    int nw, nr, no;
    logic [7:0] rv;
    bit bad;
    bus_cycle(ADDR_PORT, 8'h09, 0, 1, nw, nr, no, rv, bad);
    model_write(ADDR_PORT, 8'h09);
    bus_cycle(DATA_PORT, 8'h33, 0, 1, nw, nr, no, rv, bad);
    model_write(DATA_PORT, 8'h33);
    checks++;
    if (nr != 0 || regs !== model_pack()) begin
      failures++;
      $display("FAIL oor_write: pulses=%0d regs=%h expected 0/%h",
               nr, regs, model_pack());
    end
    bus_cycle(DATA_PORT, 8'h00, 1, 0, nw, nr, no, rv, bad);
    checks++;
    if (no != (RB ? HOLD - WCYC : 0) || bad || (RB && rv !== 8'hFF)) begin
      failures++;
      $display("FAIL oor_read: oe=%0d dout=%h bad=%0d expected FF", no, rv, bad);
    end
  endtask

  task automatic test_inta();
    int nw = 0, no = 0, nr = 0;
    @(negedge clk);
    a = DATA_PORT; din = 8'h5A;
    iorq_n = 1'b0; m1_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (wait_n !== 1'b1) nw++;
      if (oe !== 1'b0) no++;
      if (reg_wr !== 1'b0) nr++;
    end
    @(negedge clk);
    bus_idle();
    @(posedge clk);
    #1;
    checks++;
    if (nw != 0 || no != 0 || nr != 0 || regs !== model_pack()) begin
      failures++;
      $display("FAIL inta: wait=%0d oe=%0d wr=%0d regs=%h expected 0/0/0/%h",
               nw, no, nr, regs, model_pack());
    end
  endtask

  task automatic test_abort();
    int nw, nr, no;
    logic [7:0] rv;
    bit bad;
    int pulses = 0;
    bus_cycle(ADDR_PORT, 8'h02, 0, 1, nw, nr, no, rv, bad);
    model_write(ADDR_PORT, 8'h02);
    @(negedge clk);
    a = DATA_PORT; din = 8'hC3;
    m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (wait_n !== 1'b0) begin
      failures++;
      $display("FAIL abort_enter: wait_n=%b expected 0", wait_n);
    end
    @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wait_n !== 1'b1) begin
      failures++;
      $display("FAIL abort_release: wait_n=%b expected 1", wait_n);
    end
    for (int i = 0; i < 4; i++) begin
      if (reg_wr === 1'b1) pulses++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (pulses != 0 || regs !== model_pack()) begin
      failures++;
      $display("FAIL abort_commit: pulses=%0d regs=%h expected 0/%h",
               pulses, regs, model_pack());
    end
    bus_idle();
  endtask

  task automatic test_reset_mid_wait();
    int nw, nr, no;
    logic [7:0] rv;
    bit bad;
    bus_cycle(ADDR_PORT, 8'h03, 0, 1, nw, nr, no, rv, bad);
    bus_cycle(DATA_PORT, 8'h11, 0, 1, nw, nr, no, rv, bad);
    @(negedge clk);
    a = DATA_PORT; din = 8'h77;
    m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wait_n !== 1'b1 || regs !== 64'd0 || reg_sel !== 8'h00
        || reg_wr !== 1'b0 || oe !== 1'b0 || dout !== 8'hFF) begin
      failures++;
      $display("FAIL rst_wait: wait_n=%b regs=%h sel=%h wr=%b oe=%b dout=%h",
               wait_n, regs, reg_sel, reg_wr, oe, dout);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (regs !== 64'd0 || reg_wr !== 1'b0) begin
      failures++;
      $display("FAIL rst_nocommit: regs=%h wr=%b expected 0/0", regs, reg_wr);
    end
    bus_cycle(DATA_PORT, 8'h00, 1, 0, nw, nr, no, rv, bad);
    checks++;
    if (no != (RB ? HOLD - WCYC : 0) || bad || (RB && rv !== 8'h00)) begin
      failures++;
      $display("FAIL rst_read: oe=%0d dout=%h bad=%0d", no, rv, bad);
    end
  endtask

  task automatic test_back_to_back();
    int nw, nr, no;
    logic [7:0] rv;
    bit bad;
    int total = 0;
    for (int i = 0; i < 8; i++) begin
      bus_cycle(ADDR_PORT, 8'(i), 0, 1, nw, nr, no, rv, bad);
      model_write(ADDR_PORT, 8'(i));
      bus_cycle(DATA_PORT, 8'(8'hE0 + i), 0, 1, nw, nr, no, rv, bad);
      model_write(DATA_PORT, 8'(8'hE0 + i));
      total += nr;
    end
    checks++;
    if (total != 8 || regs !== model_pack()) begin
      failures++;
      $display("FAIL b2b: pulses=%0d regs=%h expected 8/%h",
               total, regs, model_pack());
    end
  endtask

  task automatic test_random();
    int nw, nr, no;
    logic [7:0] rv;
    bit bad;
    for (int n = 0; n < 40; n++) begin
      int op;
      int k;
      logic [15:0] addr;
      logic [7:0] d;
      bit r, w, hit;
      int exp_wait, exp_wr, exp_oe;
      logic [7:0] exp_rd;
      op = $urandom_range(0, 5);
      d = 8'($urandom);
      r = 0; w = 0;
      addr = DATA_PORT;
      unique case (op)
        0: begin addr = ADDR_PORT; w = 1; d = 8'($urandom_range(0, 11)); end
        1: begin w = 1; end
        2: begin addr = ADDR_PORT; r = 1; end
        3: begin r = 1; end
        4: begin
          addr = ($urandom_range(0, 1) == 0) ? ADDR_PORT : DATA_PORT;
          r = 1; w = 1;
          if (addr == ADDR_PORT) d = 8'($urandom_range(0, 11));
        end
        default: begin
          k = $urandom_range(0, 14);
          if (k >= 8) k++;
          addr = DATA_PORT ^ (16'h1 << k);
          r = $urandom_range(0, 1) == 1;
          w = !r;
        end
      endcase
      hit = (addr == ADDR_PORT) || (addr == DATA_PORT);
      exp_wait = (hit && addr == DATA_PORT) ? WCYC : 0;
      exp_wr = (hit && w && addr == DATA_PORT && m_sel < 8) ? 1 : 0;
      exp_oe = (RB && hit && r && !w) ? HOLD - exp_wait : 0;
      exp_rd = model_read(addr);
      bus_cycle(addr, d, r, w, nw, nr, no, rv, bad);
      if (hit && w) model_write(addr, d);
      checks++;
      if (nw != exp_wait || nr != exp_wr || no != exp_oe || bad) begin
        failures++;
        $display("FAIL rand_ctl[%0d]: op=%0d a=%h wait=%0d wr=%0d oe=%0d bad=%0d exp %0d/%0d/%0d",
                 n, op, addr, nw, nr, no, bad, exp_wait, exp_wr, exp_oe);
      end
      checks++;
      if ((exp_oe > 0 && rv !== exp_rd) || regs !== model_pack()
          || reg_sel !== m_sel) begin
        failures++;
        $display("FAIL rand_dat[%0d]: dout=%h/%h regs=%h/%h sel=%h/%h",
                 n, rv, exp_rd, regs, model_pack(), reg_sel, m_sel);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus_idle();
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_readback();
    test_out_of_range();
    test_inta();
    test_abort();
    test_reset_mid_wait();
    do_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
